// File: rtl/intt_engine.sv
// Kyber inverse NTT engine: in-place Gentleman-Sande layers (len 2..128, k counting
// down) followed by a scale pass by 128^-1 mod Q over one 256-entry coefficient array.
module intt_engine #(
   parameter int DEPTH = 8,
   parameter int Q     = 3329,
   parameter int NINV  = 3303
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             load_we,
   input  logic [DEPTH-1:0] load_addr,
   input  logic [11:0]      load_data,
   input  logic [DEPTH-1:0] rd_addr,
   output logic [11:0]      rd_data,
   output logic             busy,
   output logic             done
);

   localparam int          N         = 1 << DEPTH;
   localparam int          BARRETT_M = (1 << 24) / Q;
   localparam logic [12:0] Q13       = 13'(Q);
   localparam logic [11:0] NINV12    = 12'(NINV);

   typedef enum logic [3:0] {
      IDLE, BF_RD, BF_WAIT, BF_CALC, BF_WR, SC_RD, SC_WAIT, SC_CALC, SC_WR, DONE
   } state_t;

   function automatic logic [11:0] cond_sub(input logic [12:0] x);
      return (x >= Q13) ? 12'(x - Q13) : x[11:0];
   endfunction

   function automatic logic [11:0] mod_add(input logic [11:0] a, input logic [11:0] b);
      return cond_sub({1'b0, a} + {1'b0, b});
   endfunction

   function automatic logic [11:0] mod_sub(input logic [11:0] b, input logic [11:0] a);
      return cond_sub({1'b0, b} + Q13 - {1'b0, a});
   endfunction

   // Barrett with a 24-bit shift: the quotient estimate is low by at most one,
   // so a single conditional subtract leaves the result canonical.
   function automatic logic [11:0] mul_mod(input logic [11:0] x, input logic [11:0] y);
      logic [23:0] p;
      logic [36:0] t;
      logic [12:0] qe;
      p  = 24'(x) * 24'(y);
      t  = 37'(p) * 37'(BARRETT_M);
      qe = 13'(t >> 24);
      return cond_sub(13'(p - 24'(qe) * 24'(Q13)));
   endfunction

   // zeta[k] = 17^bitrev7(k) mod Q, packed 12 bits per entry
   function automatic logic [128*12-1:0] gen_zetas();
      logic [128*12-1:0] tab;
      logic [6:0]        e;
      logic [6:0]        br;
      int unsigned       z;
      tab = '0;
      z   = 1;
      for (int n = 0; n < 128; n++) begin
         e = 7'(n);
         for (int b = 0; b < 7; b++) br[b] = e[6-b];
         tab[32'(br)*12 +: 12] = 12'(z);
         z = (z * 17) % Q;
      end
      return tab;
   endfunction

   localparam logic [128*12-1:0] ZETA_TAB = gen_zetas();

   logic [11:0]      mem [N];
   state_t           state;
   logic [DEPTH:0]   len;
   logic [DEPTH:0]   grp;
   logic [DEPTH-1:0] j;
   logic [DEPTH-1:0] idx;
   logic [6:0]       k;
   logic [DEPTH:0]   grp_next;
   logic             last_j;
   logic             sc_phase;
   logic [DEPTH-1:0] addr_a;
   logic [DEPTH-1:0] addr_b;

   logic [11:0]      a_p0;
   logic [11:0]      b_p0;
   logic [11:0]      zeta_p0;
   logic [11:0]      res_a_p1;
   logic [11:0]      diff_p1;
   logic [11:0]      res_b_p2;
   logic [11:0]      mul_x;
   logic [11:0]      mul_y;
   logic [11:0]      mul_r;

   assign grp_next = grp + (len << 1);
   assign last_j   = ({1'b0, j} == grp + len - (DEPTH+1)'(1));
   assign sc_phase = (state == SC_RD) || (state == SC_WAIT) ||
                     (state == SC_CALC) || (state == SC_WR);

   always_comb begin
      addr_a = j;
      addr_b = j + len[DEPTH-1:0];
      if (sc_phase) begin
         addr_a = idx;
         addr_b = idx + DEPTH'(1);
      end
   end

   // one shared modular multiplier: butterfly twiddle, or the two scale products
   always_comb begin
      mul_x = a_p0;
      mul_y = NINV12;
      if (state == BF_CALC) begin
         mul_x = zeta_p0;
         mul_y = diff_p1;
      end else if (state == SC_CALC) begin
         mul_x = b_p0;
      end
   end

   assign mul_r = mul_mod(mul_x, mul_y);

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
         len   <= '0;
         grp   <= '0;
         j     <= '0;
         idx   <= '0;
         k     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state <= BF_RD;
                  busy  <= 1'b1;
                  len   <= (DEPTH+1)'(2);
                  k     <= 7'd127;
                  grp   <= '0;
                  j     <= '0;
                  idx   <= '0;
               end
            end
            BF_RD:   state <= BF_WAIT;
            BF_WAIT: state <= BF_CALC;
            BF_CALC: state <= BF_WR;
            BF_WR: begin
               state <= BF_RD;
               if (last_j) begin
                  k <= k - 7'd1;
                  if (grp_next == (DEPTH+1)'(N)) begin
                     if (len == (DEPTH+1)'(N/2)) begin
                        state <= SC_RD;
                        idx   <= '0;
                     end else begin
                        len <= len << 1;
                        grp <= '0;
                        j   <= '0;
                     end
                  end else begin
                     grp <= grp_next;
                     j   <= grp_next[DEPTH-1:0];
                  end
               end else begin
                  j <= j + DEPTH'(1);
               end
            end
            SC_RD:   state <= SC_WAIT;
            SC_WAIT: state <= SC_CALC;
            SC_CALC: state <= SC_WR;
            SC_WR: begin
               idx <= idx + DEPTH'(2);
               if (idx == DEPTH'(N-2)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  state <= SC_RD;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      case (state)
         // stage 0: operand and twiddle fetch
         BF_RD, SC_RD: begin
            a_p0    <= mem[addr_a];
            b_p0    <= mem[addr_b];
            zeta_p0 <= ZETA_TAB[32'(k)*12 +: 12];
         end
         // stage 1: GS sum/difference, or first scale product
         BF_WAIT: begin
            res_a_p1 <= mod_add(a_p0, b_p0);
            diff_p1  <= mod_sub(b_p0, a_p0);
         end
         SC_WAIT: res_a_p1 <= mul_r;
         // stage 2: twiddle product, or second scale product
         BF_CALC, SC_CALC: res_b_p2 <= mul_r;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (load_we && !busy)
         mem[load_addr] <= cond_sub({1'b0, load_data});
      if (state == BF_WR || state == SC_WR) begin
         mem[addr_a] <= res_a_p1;
         mem[addr_b] <= res_b_p2;
      end
   end

   always_ff @(posedge clk) begin
      if (reset)
         rd_data <= '0;
      else
         rd_data <= mem[rd_addr];
   end

endmodule

// File: doc/intt_engine.md
Name: intt_engine

Overview:
- Inverse NTT engine for Kyber (n=256, q=3329); converts an NTT-domain polynomial back to normal coefficient form.
- Mirrors the forward NTT controller: runs Gentleman-Sande butterflies with len 2..128 and k counting down, then applies the final scaling by 128^-1 mod q.
- Holds one 256-entry coefficient array, loaded and read through simple address/data ports.
- Sits downstream of the pointwise multiplier and feeds decode/compress.

Parameters:
- DEPTH, 8, log2 of coefficient count (256).
- Q, 3329, modulus.
- NINV, 3303, 128^-1 mod Q used in the scale pass.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  begin transform; sampled only in IDLE.
- load_we  input  1  write load_data to load_addr; honoured only when busy=0.
- load_addr  input  8  load address.
- load_data  input  12  NTT-domain coefficient.
- rd_addr  input  8  read address.
- rd_data  output  12  coefficient at rd_addr, registered, 1-cycle latency.
- busy  output  1  transform in progress.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: busy=0, done=0, rd_data=0, FSM=IDLE, counters cleared. Array contents are not cleared.
- Load path:
  - On load_we with busy=0: store load_data, reduced to [0,Q) by one conditional subtract of Q (12-bit input < 2Q).
  - load_we while busy=1: ignored.
- Read path: rd_data <= array[rd_addr] every cycle. The value is valid only when busy=0; contents while busy are don't-care.
- FSM states: IDLE, BF_RD, BF_WAIT, BF_CALC, BF_WR, SC_RD, SC_WAIT, SC_CALC, SC_WR, DONE.
- IDLE:
  - start=1 -> BF_RD.
  - Initialise len=2, k=127, grp=0, j=0.
  - busy=1 from the next cycle.
- Butterfly slot, 4 cycles: BF_RD -> BF_WAIT -> BF_CALC -> BF_WR.
  - Read a=f[j], b=f[j+len]; zeta=17^bitrev7(k) mod Q, taken from the shared zeta_rom (1-cycle read).
  - Write f[j]=(a+b) mod Q and f[j+len]=zeta*(b-a) mod Q.
  - All results canonical in [0,Q). Subtraction is done as b-a+Q, then reduced. Product is 24 bits, then reduced; reduction method is free, but the result must be exact.
- Indexing:
  - j runs from grp to grp+len-1.
  - After the last j of a group: grp += 2*len, k -= 1.
  - When grp reaches 256: len doubles and grp=0.
  - After the len=128 layer (k ends at 0): -> SC_RD with idx=0.
  - Total: 7 layers x 128 slots = 896 butterfly slots = 3584 cycles.
- Scale slot, 4 cycles: SC_RD -> SC_WAIT -> SC_CALC -> SC_WR.
  - f[idx] = f[idx]*NINV mod Q and f[idx+1] = f[idx+1]*NINV mod Q; idx += 2.
  - 128 slots = 512 cycles.
- After the last scale slot -> DONE.
- Timing: busy is high for exactly 4096 cycles. done=1 for exactly one cycle, in the first cycle with busy=0, then IDLE.
- start while busy or in DONE: ignored, no restart.
- Reset mid-operation: next cycle IDLE, busy=0, done=0, no done pulse. Partially transformed array contents are left as-is.
- Simultaneous start and load_we in IDLE: the load is committed first, and the transform uses the updated value.
- Transform is in place; the array holds the result after done.

Test Plan:
1. Assert reset for 2 cycles -> busy=0, done=0, rd_data=0; deassert, idle 10 cycles -> outputs unchanged.
2. Load even addresses=1, odd=0; pulse start -> busy high for exactly 4096 cycles, single done pulse; read f[0]=1, f[1..255]=0.
3. Load even=0, odd=1 (NTT of X) -> after done, f[1]=1, all others 0; repeat with odd=5 -> f[1]=5.
4. load_data=3330 at addr 7, then read addr 7 -> rd_data=1 one cycle after rd_addr is applied; load_we pulsed during busy -> array unchanged after done.
5. Start the test-2 transform and assert reset at cycle 1000 -> busy=0 the next cycle, no done. Reload test-2 vector, start -> correct result and done at 4096.
6. 20 random NTT-domain vectors (coefficients in [0,3329)) -> output matches golden Kyber invntt (plain domain, scaled by 3303) bit-exactly; a start pulse mid-run has no effect on timing or result.
